mem_read_streamer: RTL and testbench
====================================

MEM_READ_STREAMER -- requirements
Module: mem_read_streamer

Interface
REQ-001 Parameter BIT_LENGTH, default 64: data word width in bits.
REQ-002 Parameter DEPTH, default 16: memory depth; AW = $clog2(DEPTH), LW = AW+1.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 base_addr  input  AW  first read address, sampled with start.
REQ-007 length  input  LW  word count 0..DEPTH, sampled with start.
REQ-008 busy  output  1  high from cycle after accepted start until done cycle inclusive-exclusive (see REQ-020).
REQ-009 done  output  1  one-cycle pulse at burst completion.
REQ-010 enb  output  1  memory read-port enable.
REQ-011 addrb  output  AW  memory read address.
REQ-012 doutb  input  BIT_LENGTH  memory read data, valid exactly one cycle after enb=1.
REQ-013 m_data  output  BIT_LENGTH  stream data.
REQ-014 m_valid  output  1  stream valid.
REQ-015 m_ready  input  1  stream ready; beat transfers when m_valid && m_ready.

Function
REQ-016 FSM states IDLE, READ, DRAIN; IDLE->READ on start with length>0; IDLE->DRAIN on start with length==0; READ->DRAIN when last read issued; DRAIN->IDLE when issued reads all transferred and buffer empty.
REQ-017 start outside IDLE SHALL be ignored (no effect on current burst, parameters not resampled).
REQ-018 Read i (0-based) SHALL use addrb = (base_addr + i) mod 2^AW; wrap-around silent.
REQ-019 Exactly length reads issued per burst; enb=0 and addrb holds last value when not issuing.
REQ-020 done=1 for exactly one cycle, in the cycle after the final beat transfer (or cycle after start accepted when length==0); busy=0 in that same cycle and after.
REQ-021 rd_vld register = enb of previous cycle; when rd_vld=1, doutb SHALL be written into a 2-entry FIFO at end of that cycle.
REQ-022 Latency: enb in cycle t -> data earliest on m_data with m_valid=1 in cycle t+2.
REQ-023 Issue rule: enb=1 in a cycle iff state READ and (occ + rd_vld - pop) <= 1, where occ = FIFO count and pop = m_valid && m_ready that cycle.
REQ-024 FIFO SHALL never overflow nor underflow; m_valid = (occ != 0); m_data = FIFO head; data in address order.
REQ-025 With m_ready held high, one beat per cycle sustained (full throughput).
REQ-026 m_valid, once high, SHALL stay high with m_data stable until transferred.
REQ-027 Simultaneous FIFO push and pop in one cycle SHALL keep occ unchanged and preserve order.
REQ-028 First enb of a burst SHALL be in the cycle after start is sampled.

Reset
REQ-029 rst_n low SHALL asynchronously force: state IDLE, busy=0, done=0, enb=0, addrb=0, m_valid=0, m_data=0, occ=0, rd_vld=0, counters 0.
REQ-030 Reset mid-burst SHALL abandon the burst: no done pulse, no further beats; next start after release begins cleanly.

Verification
REQ-031 base_addr=2, length=4, m_ready=1, start in cycle 0 -> enb cycles 1-4 addr 2,3,4,5; m_valid cycles 3-6 with mem[2..5]; done cycle 7 only; busy 1-6.
REQ-032 base_addr=14, length=4, DEPTH=16 -> addrb 14,15,0,1; beats mem[14],mem[15],mem[0],mem[1].
REQ-033 length=0, start cycle 0 -> no enb, no m_valid, done=1 in cycle 1, busy never high.
REQ-034 length=8, m_ready random 50% plus 10-cycle low stall -> exactly 8 beats, in order, m_data stable while stalled, occ never >2, enb stops during stall.
REQ-035 start pulsed again mid-burst with different base_addr/length -> ignored; original burst completes unchanged.
REQ-036 rst_n low during cycle 3 of a length=8 burst -> all outputs 0 asynchronously; no done; new burst after release correct.

Source files
------------

// File: rtl/mem_read_streamer.sv
// Burst reader: issues `length` reads from a 1-cycle-latency memory port
// starting at base_addr and streams the words out through a 2-entry skid FIFO.
module mem_read_streamer #(
  parameter  int BIT_LENGTH = 64,
  parameter  int DEPTH      = 16,
  localparam int AW         = $clog2(DEPTH),
  localparam int LW         = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [AW-1:0]         base_addr,
  input  logic [LW-1:0]         length,
  output logic                  busy,
  output logic                  done,
  output logic                  enb,
  output logic [AW-1:0]         addrb,
  input  logic [BIT_LENGTH-1:0] doutb,
  output logic [BIT_LENGTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

  state_t                r_state;
  logic [AW-1:0]         r_base;
  logic [AW-1:0]         r_addr_last;
  logic [LW-1:0]         r_len;
  logic [LW-1:0]         r_issued;
  logic                  r_rd_vld;
  logic                  r_busy;
  logic                  r_done;
  logic [BIT_LENGTH-1:0] r_fifo [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_occ;

  logic                  w_push;
  logic                  w_pop;
  logic [2:0]            w_occ_after;
  logic                  w_enb;
  logic [AW-1:0]         w_issue_addr;
  logic [LW-1:0]         w_issued_inc;
  logic                  w_last_issue;

  assign w_push       = r_rd_vld;
  assign w_pop        = (r_occ != 2'd0) && m_ready;
  assign w_occ_after  = {1'b0, r_occ} + {2'b00, r_rd_vld} - {2'b00, w_pop};
  // A read may only go out if its data is guaranteed a FIFO slot next cycle.
  assign w_enb        = (r_state == S_READ) && (w_occ_after <= 3'd1);
  assign w_issue_addr = r_base + r_issued[AW-1:0];
  assign w_issued_inc = r_issued + LW'(1);
  assign w_last_issue = w_enb && (w_issued_inc == r_len);

  assign enb     = w_enb;
  assign addrb   = w_enb ? w_issue_addr : r_addr_last;
  assign m_valid = (r_occ != 2'd0);
  assign m_data  = r_fifo[r_rd_ptr];
  assign busy    = r_busy;
  assign done    = r_done;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_fifo[gi] <= '0;
        end else if (w_push && (r_wr_ptr == gi[0])) begin
          r_fifo[gi] <= doutb;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_addr_last <= '0;
      r_len       <= '0;
      r_issued    <= '0;
      r_rd_vld    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_occ       <= 2'd0;
    end else begin
      r_rd_vld <= w_enb;
      r_done   <= 1'b0;
      r_occ    <= w_occ_after[1:0];
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      if (w_enb) begin
        r_addr_last <= w_issue_addr;
        r_issued    <= w_issued_inc;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base   <= base_addr;
            r_len    <= length;
            r_issued <= '0;
            if (length != '0) begin
              r_state <= S_READ;
              r_busy  <= 1'b1;
            end else begin
              // Empty burst: done pulses next cycle, busy never rises.
              r_state <= S_DRAIN;
              r_done  <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (w_last_issue) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if ((r_len == '0) && !r_rd_vld && (r_occ == 2'd0)) begin
            r_state <= S_IDLE;
          end else if (!r_rd_vld && (r_occ == 2'd1) && w_pop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_streamer.sv
// Directed bench for mem_read_streamer: table of bursts plus reset-mid-burst sequence.
module tb_mem_read_streamer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  base_addr;
  logic [4:0]  length;
  logic        busy;
  logic        done;
  logic        enb;
  logic [3:0]  addrb;
  logic [63:0] doutb;
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_ready;

  logic [63:0] mem [16];
  int passed;
  int total;

  typedef struct {
    logic [3:0] base;
    logic [4:0] len;
    int         mode;      // 0: ready high, 1: random ready + stall, 2: ignored restart
    int         exp_done;  // -1: not fixed
    int         exp_last;
  } vec_t;

  vec_t vecs [8];

  mem_read_streamer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .enb       (enb),
    .addrb     (addrb),
    .doutb     (doutb),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (enb) doutb <= mem[addrb];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  task automatic run_burst(input logic [3:0] b, input logic [4:0] n, input int mode,
                           input int exp_done, input int exp_last);
    int issued, beats, done_cyc, first_enb, occ_est, cnt_m1, cnt_m2;
    logic prev_stall;
    logic [63:0] prev_data;
    logic [3:0] a;
    issued = 0; beats = 0; done_cyc = -1; first_enb = -1;
    cnt_m1 = 0; cnt_m2 = 0; prev_stall = 1'b0; prev_data = '0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = n;
    m_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      occ_est = cnt_m2 - beats;
      chk("m_valid_model", m_valid, occ_est != 0);
      chk("occ_le_2", occ_est <= 2, 1);
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_data);
      end
      if (mode == 1 && c >= 9 && c <= 14) chk("stall_enb", enb, 0);
      if (enb) begin
        a = 4'(b + 4'(issued));
        chk("addrb", addrb, a);
        if (first_enb < 0) first_enb = c;
        issued++;
      end
      if (m_valid && m_ready) begin
        a = 4'(b + 4'(beats));
        chk("beat_data", m_data, mem[a]);
        beats++;
      end
      if (done) begin
        done_cyc = c;
        break;
      end
      chk("busy", busy, (n != 0) && (c >= 1));
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      cnt_m2 = cnt_m1;
      cnt_m1 = cnt_m1 + int'(enb);
      @(posedge clk); #1;
      start = 1'b0;
      if (mode == 1) m_ready = (c + 1 >= 5 && c + 1 <= 14) ? 1'b0 : 1'($urandom_range(0, 1));
      else           m_ready = 1'b1;
      if (mode == 2 && c + 1 == 2) begin
        start = 1'b1; base_addr = 4'd9; length = 5'd3;
      end
    end
    chk("done_seen", done_cyc >= 0, 1);
    if (exp_done >= 0) chk("done_cycle", done_cyc, exp_done);
    chk("busy_at_done", busy, 0);
    chk("reads_issued", issued, n);
    chk("beats", beats, n);
    if (n != 0) begin
      chk("first_enb", first_enb, 1);
      chk("addr_hold", addrb, exp_last);
    end
    $display("burst base=%0d len=%0d mode=%0d done_cycle=%0d reads=%0d beats=%0d",
             b, n, mode, done_cyc, issued, beats);
    start = 1'b0;
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_enb", enb, 0);
    chk("idle_valid", m_valid, 0);
  endtask

  initial begin
    int bad;
    passed = 0; total = 0;
    for (int i = 0; i < 16; i++)
      mem[i] = (64'(i) * 64'h0101_0101_0101_0101) ^ 64'hA5A5_5A5A_0F0F_F0F0;
    doutb = '0;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b1;

    vecs[0] = '{base: 4'd2,  len: 5'd4,  mode: 0, exp_done: 7,  exp_last: 5};
    vecs[1] = '{base: 4'd14, len: 5'd4,  mode: 0, exp_done: 7,  exp_last: 1};
    vecs[2] = '{base: 4'd0,  len: 5'd0,  mode: 0, exp_done: 1,  exp_last: 0};
    vecs[3] = '{base: 4'd15, len: 5'd1,  mode: 0, exp_done: 4,  exp_last: 15};
    vecs[4] = '{base: 4'd0,  len: 5'd16, mode: 0, exp_done: 19, exp_last: 15};
    vecs[5] = '{base: 4'd5,  len: 5'd8,  mode: 1, exp_done: -1, exp_last: 12};
    vecs[6] = '{base: 4'd6,  len: 5'd5,  mode: 2, exp_done: 8,  exp_last: 10};
    vecs[7] = '{base: 4'd7,  len: 5'd16, mode: 0, exp_done: 19, exp_last: 6};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_enb", enb, 0);
    chk("rst_addrb", addrb, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++)
      run_burst(vecs[v].base, vecs[v].len, vecs[v].mode, vecs[v].exp_done, vecs[v].exp_last);

    // Reset asserted inside cycle 3 of a length-8 burst.
    @(posedge clk); #1;
    start = 1'b1; base_addr = 4'd0; length = 5'd8; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    chk("pre_rst_valid", m_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_enb", enb, 0);
    chk("arst_addrb", addrb, 0);
    chk("arst_valid", m_valid, 0);
    chk("arst_data", m_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done || m_valid || enb || busy) bad++;
    end
    chk("post_rst_quiet", bad, 0);
    $display("reset mid-burst: quiet_violations=%0d", bad);
    run_burst(4'd3, 5'd5, 0, 8, 7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
